// File: rtl/rc5_words_to_bytes_if.sv
// ---------------------------------------------------------------------------
// rc5_words_to_bytes_if
// Signal bundle for the RC5 key read-back unit: the dump request/status, the
// word-memory read port and the valid/ready key-byte stream.
//   start       request to begin a dump (to the unit)
//   busy, done  status from the unit
//   L_address   word address to L memory; L_sub_i registered read data back
//   byte_o, byte_index, byte_valid   byte stream from the unit
//   byte_ready  consumer acceptance
// Modports: master = the read-back unit, slave = its environment.
// ---------------------------------------------------------------------------
interface rc5_words_to_bytes_if #(
   parameter int w        = 32,
   parameter int b_length = 4,
   parameter int c_length = 2
);
   logic                start;
   logic                busy;
   logic                done;
   logic [c_length-1:0] L_address;
   logic [w-1:0]        L_sub_i;
   logic [7:0]          byte_o;
   logic [b_length-1:0] byte_index;
   logic                byte_valid;
   logic                byte_ready;

   modport master (
      input  start, L_sub_i, byte_ready,
      output busy, done, L_address, byte_o, byte_index, byte_valid
   );

   modport slave (
      output start, L_sub_i, byte_ready,
      input  busy, done, L_address, byte_o, byte_index, byte_valid
   );
endinterface

// File: rtl/rc5_words_to_bytes.sv
// ---------------------------------------------------------------------------
// rc5_words_to_bytes
// Reads the c-word RC5 L array from word memory (registered read port, data
// one cycle after the address) and streams it out as b key bytes over a
// valid/ready interface. Used to read back / export a loaded key.
//
// Ports:
//   clk1  single clock, rising edge
//   rst   synchronous active-high reset (aborts a dump)
//   bus   rc5_words_to_bytes_if.master: start, busy, done, L_address,
//         L_sub_i, byte_o, byte_index, byte_valid, byte_ready
//
// Build option: define W2B_BIG_ENDIAN_EN to emit each word MSB byte first
// (a partial last word then emits its top bytes). Default is little-endian.
// Timing is the same in both builds.
// ---------------------------------------------------------------------------
module rc5_words_to_bytes #(
   parameter int b        = 16,
   parameter int b_length = 4,
   parameter int w        = 32,
   parameter int u        = 4,
   parameter int c_length = 2
) (
   input  logic                 clk1,
   input  logic                 rst,
   rc5_words_to_bytes_if.master bus
);

   localparam int UW = (u > 1) ? $clog2(u) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, EMIT, DONE} state_t;

   state_t              state, state_nxt;
   logic [w-1:0]        shreg, shreg_nxt;
   logic [b_length-1:0] byte_cnt, byte_cnt_nxt;
   logic [c_length-1:0] word_idx, word_idx_nxt;
   logic [UW-1:0]       in_word, in_word_nxt;
   logic                xfer;

   always_ff @(posedge clk1) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         byte_cnt <= '0;
         word_idx <= '0;
         in_word  <= '0;
      end else begin
         state    <= state_nxt;
         shreg    <= shreg_nxt;
         byte_cnt <= byte_cnt_nxt;
         word_idx <= word_idx_nxt;
         in_word  <= in_word_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      shreg_nxt    = shreg;
      byte_cnt_nxt = byte_cnt;
      word_idx_nxt = word_idx;
      in_word_nxt  = in_word;
      xfer         = (state == EMIT) && bus.byte_ready;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt    = FETCH;
               word_idx_nxt = '0;
               byte_cnt_nxt = '0;
            end
         end
         // Address is already on L_address; memory registers it this edge.
         FETCH: state_nxt = LOAD;
         LOAD: begin
            shreg_nxt   = bus.L_sub_i;
            in_word_nxt = '0;
            state_nxt   = EMIT;
         end
         EMIT: begin
            if (xfer) begin
`ifdef W2B_BIG_ENDIAN_EN
               shreg_nxt = shreg << 8;
`else
               shreg_nxt = shreg >> 8;
`endif
               byte_cnt_nxt = byte_cnt + 1'b1;
               in_word_nxt  = in_word + 1'b1;
               // The byte-count test comes first so a partial last word
               // finishes without ever fetching the next address.
               if (byte_cnt == b_length'(b - 1)) begin
                  state_nxt = DONE;
               end else if (in_word == UW'(u - 1)) begin
                  word_idx_nxt = word_idx + 1'b1;
                  state_nxt    = FETCH;
               end
            end
         end
         DONE: begin
            word_idx_nxt = '0;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // All outputs come straight from registers: nothing depends on byte_ready.
   assign bus.L_address  = word_idx;
`ifdef W2B_BIG_ENDIAN_EN
   assign bus.byte_o     = shreg[w-1 -: 8];
`else
   assign bus.byte_o     = shreg[7:0];
`endif
   assign bus.byte_index = byte_cnt;
   assign bus.byte_valid = (state == EMIT);
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_rc5_words_to_bytes.sv
// ---------------------------------------------------------------------------
// tb_rc5_words_to_bytes
// Directed bench for rc5_words_to_bytes. Two instances share clk1/rst/ready:
// dut_a (b=16, four full words) and dut_b (b=10, partial last word). Each
// has a registered-read L memory model. Inputs are driven and outputs
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rc5_words_to_bytes;

   logic clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   logic rst, start, ready, sel;
   int   n_checks = 0;
   int   n_errors = 0;

   rc5_words_to_bytes_if #(.w(32), .b_length(4), .c_length(2)) ifa ();
   rc5_words_to_bytes_if #(.w(32), .b_length(4), .c_length(2)) ifb ();

   assign ifa.start      = start & ~sel;
   assign ifb.start      = start & sel;
   assign ifa.byte_ready = ready;
   assign ifb.byte_ready = ready;

   logic [31:0] mem_a [4];
   logic [31:0] mem_b [4];

   always @(posedge clk1) begin
      ifa.L_sub_i <= mem_a[ifa.L_address];
      ifb.L_sub_i <= mem_b[ifb.L_address];
   end

   rc5_words_to_bytes #(.b(16), .b_length(4), .w(32), .u(4), .c_length(2))
      dut_a (.clk1(clk1), .rst(rst), .bus(ifa));
   rc5_words_to_bytes #(.b(10), .b_length(4), .w(32), .u(4), .c_length(2))
      dut_b (.clk1(clk1), .rst(rst), .bus(ifb));

   wire       s_valid = sel ? ifb.byte_valid : ifa.byte_valid;
   wire [7:0] s_byte  = sel ? ifb.byte_o     : ifa.byte_o;
   wire [3:0] s_index = sel ? ifb.byte_index : ifa.byte_index;
   wire       s_busy  = sel ? ifb.busy       : ifa.busy;
   wire       s_done  = sel ? ifb.done       : ifa.done;
   wire [1:0] s_addr  = sel ? ifb.L_address  : ifa.L_address;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hand-derived byte k of each dump. dut_a memory holds bytes 0x00..0x0F in
   // order; dut_b word 2 is 0xDDCCBBAA.
   function automatic logic [7:0] exp_byte(input logic s, input int k);
      logic [7:0] v;
`ifdef W2B_BIG_ENDIAN_EN
      v = 8'((k & ~3) | (3 - (k & 3)));
      if (s && k == 8) v = 8'hDD;
      if (s && k == 9) v = 8'hCC;
`else
      v = 8'(k);
      if (s && k == 8) v = 8'hAA;
      if (s && k == 9) v = 8'hBB;
`endif
      return v;
   endfunction

   // mode 0: ready held high; mode 1: ready pattern 1,0,0,1.
   // restart_at: pulse start while busy when this byte transfers (-1 = never).
   // abort_at: assert rst once this byte has transferred (-1 = never).
   task automatic run_dump(input logic s, input int mode, input int restart_at,
                           input int abort_at);
      int         nb       = 0;
      int         cyc      = 1;
      int         first_v  = -1;
      int         done_cnt = 0;
      int         done_cyc = -1;
      int         max_addr = 0;
      int         nbytes   = s ? 10 : 16;
      int         nwords   = s ? 3 : 4;
      logic       stalled  = 1'b0;
      logic [7:0] hold_b   = '0;
      logic [3:0] hold_i   = '0;

      sel = s;
      ready = 1'b1;
      @(negedge clk1);
      start = 1'b1;
      @(negedge clk1);
      start = 1'b0;
      while (cyc < 300) begin
         ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (abort_at >= 0 && nb == abort_at + 1) begin
            rst = 1'b1;
            @(negedge clk1);
            rst = 1'b0;
            check("abort_valid", 32'(s_valid), 0);
            check("abort_busy", 32'(s_busy), 0);
            return;
         end
         if (cyc == 1) check("fetch_addr0", 32'(s_addr), 0);
         if (int'(s_addr) > max_addr) max_addr = int'(s_addr);
         if (stalled) begin
            check("stall_valid", 32'(s_valid), 1);
            check("stall_byte", 32'(s_byte), 32'(hold_b));
            check("stall_index", 32'(s_index), 32'(hold_i));
         end
         stalled = 1'b0;
         if (s_valid) begin
            if (first_v < 0) first_v = cyc;
            if (ready) begin
               check("byte", 32'(s_byte), 32'(exp_byte(s, nb)));
               check("index", 32'(s_index), 32'(nb));
               if (nb == restart_at) start = 1'b1;
               nb++;
            end else begin
               stalled = 1'b1;
               hold_b  = s_byte;
               hold_i  = s_index;
            end
         end
         if (s_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (done_cnt > 0 && cyc >= done_cyc + 2) break;
         @(negedge clk1);
         start = 1'b0;
         cyc++;
      end
      check("dump_finished", 32'(cyc < 300), 1);
      check("byte_count", 32'(nb), 32'(nbytes));
      check("done_pulses", 32'(done_cnt), 1);
      check("max_addr", 32'(max_addr), 32'(nwords - 1));
      check("idle_after", 32'(s_busy), 0);
      if (mode == 0) begin
         // FETCH, LOAD, then first byte on the third falling edge; done after
         // b bytes plus two bubbles per word plus one.
         check("first_valid_cyc", 32'(first_v), 3);
         check("done_cyc", 32'(done_cyc), 32'(nbytes + 2 * nwords + 1));
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      ready = 1'b0;
      sel   = 1'b0;
      mem_a[0] = 32'h03020100;
      mem_a[1] = 32'h07060504;
      mem_a[2] = 32'h0B0A0908;
      mem_a[3] = 32'h0F0E0D0C;
      mem_b[0] = 32'h03020100;
      mem_b[1] = 32'h07060504;
      mem_b[2] = 32'hDDCCBBAA;
      mem_b[3] = 32'hFFFFFFFF;
      repeat (3) @(negedge clk1);
      rst = 1'b0;

      check("rst_valid", 32'(ifa.byte_valid), 0);
      check("rst_busy", 32'(ifa.busy), 0);
      check("rst_done", 32'(ifa.done), 0);
      check("rst_byte", 32'(ifa.byte_o), 0);
      check("rst_index", 32'(ifa.byte_index), 0);
      check("rst_addr", 32'(ifa.L_address), 0);

      run_dump(1'b0, 0, -1, -1);   // basic dump
      run_dump(1'b0, 1, -1, -1);   // backpressure
      run_dump(1'b0, 0, -1, 5);    // reset mid-dump
      run_dump(1'b0, 0, -1, -1);   // fresh start after abort
      run_dump(1'b0, 0, 7, -1);    // start while busy is ignored
      run_dump(1'b1, 0, -1, -1);   // partial last word

      // rst and start together: rst wins
      sel = 1'b0;
      @(negedge clk1);
      start = 1'b1;
      rst   = 1'b1;
      @(negedge clk1);
      start = 1'b0;
      rst   = 1'b0;
      check("rst_start_busy", 32'(ifa.busy), 0);
      @(negedge clk1);
      check("rst_start_idle", 32'(ifa.busy), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
